instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential instruction-fetch stage that sits directly upstream of the main decoder. It owns the PC and requests instructions from a variable-latency instruction memory. It presents the fetched word (with OpCode/Funct split out) to the decoder and datapath, then computes the next PC from the decoder's PCSrc/Branch outputs and the ALU Zero flag. It replaces the free-running PC register and PC mux of the single-cycle datapath with a stallable fetch/issue handshake.

## Interface
- PC_RESET, 32'h0040_0000, PC loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, equal to PC.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- Instruction  out  32  registered instruction (IR).
- OpCode  out  6  Instruction[31:26].
- Funct  out  6  Instruction[5:0].
- instr_valid  out  1  IR holds an instruction to execute this cycle.
- pc_out  out  32  PC of the instruction in IR.
- pc_plus4  out  32  pc_out + 4, used as the jal/jalr link value.
- PCSrc  in  2  from decoder: 00 sequential/branch, 01 j/jal, 10 jr/jalr, 11 reserved.
- Branch  in  1  from decoder.
- Zero  in  1  from ALU.
- jr_target  in  32  rs register value.
- stall  in  1  hold current instruction (datapath busy).
- retired  out  CNT_W  count of completed instructions.

## Operation
- States:
  - FETCH: imem_req=1, imem_addr=PC.
  - ISSUE: instr_valid=1, imem_req=0.
- FETCH:
  - If imem_ready, latch imem_rdata into IR and go to ISSUE.
  - Otherwise stay in FETCH with the request and address held stable.
- ISSUE:
  - If stall, stay in ISSUE with IR, PC and retired unchanged.
  - Otherwise PC<=next_pc, retired<=retired+1 (wraps modulo 2^CNT_W), and go to FETCH.
- next_pc (combinational on IR and inputs), by PCSrc:
  - 00: pc_plus4 + (sext(IR[15:0])<<2) if Branch&Zero, else pc_plus4.
  - 01: {pc_plus4[31:28], IR[25:0], 2'b00}.
  - 10: {jr_target[31:2], 2'b00}; low bits are silently cleared.
  - 11: pc_plus4.
- All adds are 32-bit and wrap. No overflow detection.
- imem_ready is ignored outside FETCH.
- OpCode, Funct and pc_plus4 are pure wiring from IR/PC.

## Timing
- Reset (reset_n low at an edge):
  - PC=PC_RESET, state FETCH, IR=0 (decodes as sll nop), retired=0.
  - The cycle after reset: imem_req=1, imem_addr=PC_RESET, instr_valid=0.
- Reset mid-FETCH or mid-ISSUE wins over every other event. An outstanding memory request is abandoned and the memory must tolerate this.
- Minimum throughput is 2 cycles per instruction (ready in the first FETCH cycle). Each imem_ready-low cycle adds 1 cycle; each stall cycle adds 1 cycle.
- Fetch latency: IR is valid the cycle after the imem_ready edge.
- PCSrc/Branch/Zero/jr_target are sampled only at the ISSUE edge where stall=0. Changes while stalled have no effect.
- stall asserted in FETCH is ignored.

## Structure
- Shared package:
  - State encoding (FETCH, ISSUE).
  - PCSrc code constants PCSRC_SEQ=2'b00, PCSRC_JUMP=2'b01, PCSRC_JR=2'b10.
  - Default PC_RESET.
  - The decoder uses the same PCSrc constants.
- One sub-module: next_pc_logic (combinational: IR, pc_plus4, PCSrc, Branch, Zero, jr_target -> next_pc).
- FSM, PC, IR and counter live in the top module.

## Test plan
- Reset: hold reset_n low 2 cycles, release -> imem_req=1, imem_addr=0x00400000, instr_valid=0, retired=0.
- Sequential, zero-wait: return 0x20080005 with immediate ready, PCSrc=00, Branch=0 -> OpCode=0x08, instr_valid for 1 cycle, next imem_addr=0x00400004, retired=1.
- Branch taken:
  - IR=0x1109FFFF at pc 0x00400008, Branch=1, Zero=1 -> next imem_addr=0x00400008.
  - Same with Zero=0 -> 0x0040000C.
- Jump and jr:
  - IR=0x08100010 at 0x00400000, PCSrc=01 -> 0x00400040.
  - PCSrc=10, jr_target=0x00400103 -> 0x00400100.
- Wait states and stall:
  - imem_ready low 3 cycles -> imem_req/addr held 4 cycles, instr_valid=0.
  - stall high 2 cycles in ISSUE -> instr_valid held 3 cycles; PC and retired change only after stall drops; PCSrc toggled during the stall is ignored.
- Reset mid-operation: reset_n low during a FETCH wait state and again during a stalled ISSUE -> next cycle PC=0x00400000, IR=0, retired=0, imem_req=1.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_unit_pkg                                               |
// | Brief   : Shared constants for the fetch stage and the main decoder.         |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
package instr_fetch_unit_pkg;

    localparam int          STATE_W          = 1;
    localparam logic [STATE_W-1:0] ST_FETCH  = 1'b0;
    localparam logic [STATE_W-1:0] ST_ISSUE  = 1'b1;

    // PCSrc encoding, also used by the decoder when it drives PCSrc
    localparam logic [1:0]  PCSRC_SEQ        = 2'b00;
    localparam logic [1:0]  PCSRC_JUMP       = 2'b01;
    localparam logic [1:0]  PCSRC_JR         = 2'b10;
    localparam logic [1:0]  PCSRC_RSVD       = 2'b11;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

    // Branch displacement: sign-extended word offset converted to bytes
    function automatic logic [31:0] branchOffset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage : instr_fetch_unit_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_next_pc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : next_pc_logic                                                      |
// | Brief   : Combinational next-PC selection for branch, jump and jr.           |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module next_pc_logic
    import instr_fetch_unit_pkg::*;
(
    input  logic [25:0] i_instrIndex,
    input  logic [31:0] i_pcPlus4,
    input  logic [1:0]  i_pcSrc,
    input  logic        i_branch,
    input  logic        i_zero,
    input  logic [31:0] i_jrTarget,
    output logic [31:0] o_nextPc
);

    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0] w_branchTarget;
    logic [31:0] w_jumpTarget;
    logic [31:0] w_jrTarget;

    assign w_branchTarget = i_pcPlus4 + branchOffset(i_instrIndex[15:0]);
    assign w_jumpTarget   = {i_pcPlus4[31:28], i_instrIndex, 2'b00};
    // Misaligned register targets are silently forced to a word boundary
    assign w_jrTarget     = i_jrTarget & c_WORD_MASK;

    always_comb begin
        o_nextPc = i_pcPlus4;
        case (i_pcSrc)
            PCSRC_SEQ:  o_nextPc = (i_branch && i_zero) ? w_branchTarget : i_pcPlus4;
            PCSRC_JUMP: o_nextPc = w_jumpTarget;
            PCSRC_JR:   o_nextPc = w_jrTarget;
            PCSRC_RSVD: o_nextPc = i_pcPlus4;
            default:    o_nextPc = i_pcPlus4;
        endcase
    end

endmodule : next_pc_logic
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_unit                                                   |
// | Brief   : Stallable fetch/issue stage owning PC, IR and retired counter.     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      Instruction,
    output logic [5:0]       OpCode,
    output logic [5:0]       Funct,
    output logic             instr_valid,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    input  logic [1:0]       PCSrc,
    input  logic             Branch,
    input  logic             Zero,
    input  logic [31:0]      jr_target,
    input  logic             stall,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_stateNext;
    logic [31:0]        r_pc;
    logic [31:0]        r_ir;
    logic [CNT_W-1:0]   r_retired;
    logic [31:0]        w_pcPlus4;
    logic [31:0]        w_nextPc;
    logic               w_capture;
    logic               w_advance;
    logic               w_fetchReq;
    logic               w_issueValid;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_FETCH: if (imem_ready) w_stateNext = ST_ISSUE;
            ST_ISSUE: if (!stall)     w_stateNext = ST_FETCH;
            default:                  w_stateNext = ST_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        w_fetchReq   = 1'b0;
        w_issueValid = 1'b0;
        case (r_state)
            ST_FETCH: w_fetchReq   = 1'b1;
            ST_ISSUE: w_issueValid = 1'b1;
            default: begin
                w_fetchReq   = 1'b0;
                w_issueValid = 1'b0;
            end
        endcase
    end

    assign w_capture = w_fetchReq && imem_ready;
    // Control inputs only matter on the single edge that leaves ISSUE
    assign w_advance = w_issueValid && !stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc      <= PC_RESET;
            r_ir      <= 32'h0000_0000;
            r_retired <= '0;
        end else begin
            if (w_capture) begin
                r_ir <= imem_rdata;
            end
            if (w_advance) begin
                r_pc      <= w_nextPc;
                r_retired <= r_retired + c_CNT_ONE;
            end
        end
    end

    assign w_pcPlus4 = r_pc + 32'd4;

    next_pc_logic u_nextPc (
        .i_instrIndex (r_ir[25:0]),
        .i_pcPlus4    (w_pcPlus4),
        .i_pcSrc      (PCSrc),
        .i_branch     (Branch),
        .i_zero       (Zero),
        .i_jrTarget   (jr_target),
        .o_nextPc     (w_nextPc)
    );

    assign imem_req    = w_fetchReq;
    assign imem_addr   = r_pc;
    assign instr_valid = w_issueValid;
    assign Instruction = r_ir;
    assign OpCode      = r_ir[31:26];
    assign Funct       = r_ir[5:0];
    assign pc_out      = r_pc;
    assign pc_plus4    = w_pcPlus4;
    assign retired     = r_retired;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_instr_fetch_unit                                                |
// | Brief   : Self-checking bench: directed table, random stream, reset cases.   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

    localparam logic [31:0] c_PC_RESET = 32'h0040_0000;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [1:0]  PCSrc;
    logic        Branch;
    logic        Zero;
    logic [31:0] jr_target;
    logic        stall;
    logic [31:0] retired;

    instr_fetch_unit #(
        .PC_RESET (c_PC_RESET),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .PCSrc       (PCSrc),
        .Branch      (Branch),
        .Zero        (Zero),
        .jr_target   (jr_target),
        .stall       (stall),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  pcSrc;
        logic        branch;
        logic        zero;
        logic [31:0] jrTarget;
        int          waits;
        int          stalls;
        logic [31:0] pc;
        logic [31:0] next;
    } vec_t;

    vec_t        vecs [7];
    int          nVec;
    int          nMis;
    logic [31:0] expPc;
    logic [31:0] expRet;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference next-PC from the architectural rules, using plain arithmetic
    function automatic logic [31:0] refNext(input logic [31:0] pc, input logic [31:0] instr,
                                            input logic [1:0] src, input logic br,
                                            input logic z, input logic [31:0] jr);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(instr[15:0])) * 4;
        case (src)
            2'b00:   return (br && z) ? seq + 32'(off) : seq;
            2'b01:   return (seq & 32'hF000_0000) | ({6'd0, instr[25:0]} * 32'd4);
            2'b10:   return (jr / 32'd4) * 32'd4;
            default: return seq;
        endcase
    endfunction

    task automatic checkFetchState(input string tag);
        check({tag, ".req"},   {31'd0, imem_req},    32'd1);
        check({tag, ".addr"},  imem_addr,            expPc);
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    // One full fetch/issue transaction; enters and leaves with the DUT in FETCH
    task automatic runInstr(input logic [31:0] instr, input int waits, input int stalls,
                            input logic [1:0] src, input logic br, input logic z,
                            input logic [31:0] jr, input logic [31:0] next);
        for (int w = 0; w < waits; w++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            stall      = 1'($urandom);
            checkFetchState("wait");
            tick();
        end
        imem_ready = 1'b1;
        imem_rdata = instr;
        stall      = 1'($urandom);
        checkFetchState("fetch");
        tick();
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        check("issue.valid",  {31'd0, instr_valid}, 32'd1);
        check("issue.req",    {31'd0, imem_req},    32'd0);
        check("issue.ir",     Instruction,          instr);
        check("issue.opcode", {26'd0, OpCode},      {26'd0, instr[31:26]});
        check("issue.funct",  {26'd0, Funct},       {26'd0, instr[5:0]});
        check("issue.pc",     pc_out,               expPc);
        check("issue.pc4",    pc_plus4,             expPc + 32'd4);
        check("issue.ret",    retired,              expRet);
        for (int s = 0; s < stalls; s++) begin
            stall     = 1'b1;
            PCSrc     = 2'($urandom);
            Branch    = 1'($urandom);
            Zero      = 1'($urandom);
            jr_target = $urandom;
            tick();
            check("stall.valid", {31'd0, instr_valid}, 32'd1);
            check("stall.pc",    pc_out,               expPc);
            check("stall.ret",   retired,              expRet);
        end
        stall     = 1'b0;
        PCSrc     = src;
        Branch    = br;
        Zero      = z;
        jr_target = jr;
        tick();
        imem_ready = 1'b0;
        PCSrc      = 2'($urandom);
        expRet     = expRet + 32'd1;
        expPc      = next;
        checkFetchState("next");
        check("next.ret", retired, expRet);
    endtask

    task automatic checkResetState(input string tag);
        check({tag, ".req"},   {31'd0, imem_req},    32'd1);
        check({tag, ".addr"},  imem_addr,            c_PC_RESET);
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, ".ir"},    Instruction,          32'd0);
        check({tag, ".ret"},   retired,              32'd0);
    endtask

    initial begin
        logic [31:0] rInstr;
        logic [31:0] rJr;
        logic [1:0]  rSrc;
        logic        rBr;
        logic        rZ;

        nVec = 0;
        nMis = 0;
        vecs[0] = '{32'h2008_0005, 2'b00, 1'b0, 1'b0, 32'h0,         0, 0, 32'h0040_0000, 32'h0040_0004};
        vecs[1] = '{32'h0000_0000, 2'b00, 1'b0, 1'b1, 32'h0,         3, 0, 32'h0040_0004, 32'h0040_0008};
        vecs[2] = '{32'h1109_FFFF, 2'b00, 1'b1, 1'b1, 32'h0,         0, 2, 32'h0040_0008, 32'h0040_0008};
        vecs[3] = '{32'h1109_FFFF, 2'b00, 1'b1, 1'b0, 32'h0,         1, 0, 32'h0040_0008, 32'h0040_000C};
        vecs[4] = '{32'h0810_0010, 2'b01, 1'b0, 1'b0, 32'h0,         0, 1, 32'h0040_000C, 32'h0040_0040};
        vecs[5] = '{32'h03E0_0008, 2'b10, 1'b0, 1'b0, 32'h0040_0103, 2, 2, 32'h0040_0040, 32'h0040_0100};
        vecs[6] = '{32'h1234_5678, 2'b11, 1'b1, 1'b1, 32'h0,         0, 0, 32'h0040_0100, 32'h0040_0104};

        reset_n    = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        PCSrc      = 2'b00;
        Branch     = 1'b0;
        Zero       = 1'b0;
        jr_target  = 32'h0;
        stall      = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        checkResetState("reset");
        expPc  = c_PC_RESET;
        expRet = 32'd0;

        for (int i = 0; i < 7; i++) begin
            check("vec.pc", expPc, vecs[i].pc);
            runInstr(vecs[i].instr, vecs[i].waits, vecs[i].stalls, vecs[i].pcSrc,
                     vecs[i].branch, vecs[i].zero, vecs[i].jrTarget, vecs[i].next);
        end

        for (int i = 0; i < 40; i++) begin
            rInstr = $urandom;
            rJr    = $urandom;
            rSrc   = 2'($urandom);
            rBr    = 1'($urandom);
            rZ     = 1'($urandom);
            runInstr(rInstr, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                     rSrc, rBr, rZ, rJr, refNext(expPc, rInstr, rSrc, rBr, rZ, rJr));
        end

        // Reset during a FETCH wait state
        imem_ready = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkResetState("rstFetch");
        expPc  = c_PC_RESET;
        expRet = 32'd0;

        runInstr(32'hAC01_0004, 1, 0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0040_0004);

        // Reset during a stalled ISSUE
        imem_ready = 1'b1;
        imem_rdata = 32'h8C22_0008;
        tick();
        imem_ready = 1'b0;
        stall      = 1'b1;
        tick();
        check("rstIssue.pre", {31'd0, instr_valid}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        stall   = 1'b0;
        checkResetState("rstIssue");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
